// File: rtl/tbird_pkg.sv
// Shared types and limits for the Thunderbird tail-light sequencer.
package tbird_pkg;
   localparam int LAMPS_MAX    = 8;
   localparam int STEP_DIV_MAX = 65535;

   typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} tbird_state_t;

   // Request priority: hazard (or both turns) beats left, left beats right.
   function automatic tbird_state_t decode_req(logic h, logic l, logic r);
      if (h || (l && r)) return HAZ;
      if (l)             return LEFT;
      if (r)             return RIGHT;
      return IDLE;
   endfunction
endpackage

// File: rtl/tbird_step_div.sv
// Step divider: tick high on the last clock of every STEP_DIV-clock step.
module tbird_step_div #(
   parameter int STEP_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);
   localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   logic [CW-1:0] r_cnt;

   assign tick = (r_cnt == CW'(STEP_DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)            r_cnt <= '0;
      else if (clr || tick)  r_cnt <= '0;
      else                   r_cnt <= r_cnt + CW'(1);
   end
endmodule

// File: rtl/tbird_seq_lights.sv
// Sequential turn/hazard lamp controller; optional brake input with TBIRD_BRAKE_EN.
module tbird_seq_lights
   import tbird_pkg::*;
#(
   parameter int LAMPS    = 3,
   parameter int STEP_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             left,
   input  logic             right,
   input  logic             hazard,
`ifdef TBIRD_BRAKE_EN
   input  logic             brake,
`endif
   output logic [LAMPS-1:0] lamp_l,
   output logic [LAMPS-1:0] lamp_r,
   output logic             busy
);
   localparam int PW = $clog2(LAMPS + 1);

   if (LAMPS < 2 || LAMPS > LAMPS_MAX) begin : g_bad_lamps
      $error("tbird_seq_lights: LAMPS out of range");
   end
   if (STEP_DIV < 1 || STEP_DIV > STEP_DIV_MAX) begin : g_bad_div
      $error("tbird_seq_lights: STEP_DIV out of range");
   end

   tbird_state_t     r_state, w_state_nx, w_req;
   logic [PW-1:0]    r_phase, w_phase_nx;
   logic             w_tick, w_clr, w_brake;
   logic [LAMPS-1:0] w_fill, w_lamp_l_nx, w_lamp_r_nx;
   logic [LAMPS-1:0] r_lamp_l, r_lamp_r;
   logic             r_busy;

`ifdef TBIRD_BRAKE_EN
   assign w_brake = brake;
`else
   assign w_brake = 1'b0;
`endif

   tbird_step_div #(.STEP_DIV(STEP_DIV)) u_div (
      .clk   (clk),
      .reset (reset),
      .clr   (w_clr),
      .tick  (w_tick)
   );

   always_comb begin
      w_req      = decode_req(hazard, left, right);
      w_state_nx = r_state;
      w_phase_nx = r_phase;
      case (r_state)
         IDLE: begin
            if (w_req != IDLE) begin
               w_state_nx = w_req;
               w_phase_nx = PW'(1);
            end
         end
         LEFT, RIGHT: begin
            if (hazard) begin
               w_state_nx = HAZ;
               w_phase_nx = PW'(1);
            end else if (w_tick) begin
               if (r_phase == '0) begin
                  w_state_nx = w_req;
                  w_phase_nx = (w_req == IDLE) ? '0 : PW'(1);
               end else if (r_phase == PW'(LAMPS)) begin
                  w_phase_nx = '0;
               end else begin
                  w_phase_nx = r_phase + PW'(1);
               end
            end
         end
         HAZ: begin
            // Only the dark half of the flash may hand over to a new request.
            if (w_tick) begin
               if (r_phase == '0) begin
                  w_state_nx = w_req;
                  w_phase_nx = (w_req == IDLE) ? '0 : PW'(1);
               end else begin
                  w_phase_nx = '0;
               end
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_phase_nx = '0;
         end
      endcase
      w_clr = (w_state_nx != r_state);
   end

   always_comb begin
      w_fill      = '0;
      w_lamp_l_nx = '0;
      w_lamp_r_nx = '0;
      for (int i = 0; i < LAMPS; i++) w_fill[i] = (i < int'(w_phase_nx));
      case (w_state_nx)
         IDLE: begin
            if (w_brake) begin
               w_lamp_l_nx = '1;
               w_lamp_r_nx = '1;
            end
         end
         LEFT: begin
            w_lamp_l_nx = w_fill;
            if (w_brake) w_lamp_r_nx = '1;
         end
         RIGHT: begin
            w_lamp_r_nx = w_fill;
            if (w_brake) w_lamp_l_nx = '1;
         end
         HAZ: begin
            if (w_phase_nx[0]) begin
               w_lamp_l_nx = '1;
               w_lamp_r_nx = '1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_phase  <= '0;
         r_lamp_l <= '0;
         r_lamp_r <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_phase  <= w_phase_nx;
         r_lamp_l <= w_lamp_l_nx;
         r_lamp_r <= w_lamp_r_nx;
         r_busy   <= (w_state_nx != IDLE);
      end
   end

   assign lamp_l = r_lamp_l;
   assign lamp_r = r_lamp_r;
   assign busy   = r_busy;
endmodule

// File: tb/tb_tbird_seq_lights.sv
// Bench: directed scenarios plus random requests against an elapsed-time lamp model.
module tb_tbird_seq_lights;
   logic clk = 1'b0;
   logic reset, left, right, hazard, brake;
   logic [2:0] a_l, a_r;
   logic [1:0] b_l, b_r;
   logic a_busy, b_busy;
   int n_run = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   tbird_seq_lights #(.LAMPS(3), .STEP_DIV(2)) dut_a (
      .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
`ifdef TBIRD_BRAKE_EN
      .brake(brake),
`endif
      .lamp_l(a_l), .lamp_r(a_r), .busy(a_busy));

   tbird_seq_lights #(.LAMPS(2), .STEP_DIV(1)) dut_b (
      .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
`ifdef TBIRD_BRAKE_EN
      .brake(brake),
`endif
      .lamp_l(b_l), .lamp_r(b_r), .busy(b_busy));

   // mode: 0 idle, 1 left, 2 right, 3 hazard; t = clocks since the current sweep began.
   typedef struct {int mode; int t; logic brk;} mdl_t;
   mdl_t ma, mb;
   logic [2:0] seq[8];

   function automatic int decode(logic h, logic l, logic r);
      if (h || (l && r)) return 3;
      if (l) return 1;
      if (r) return 2;
      return 0;
   endfunction

   function automatic mdl_t mdl_next(mdl_t m, int lamps, int sd, logic h, logic l, logic r, logic brk);
      mdl_t n;
      int period, d;
      n = m;
      n.brk = brk;
      period = (m.mode == 3) ? 2 * sd : (lamps + 1) * sd;
      d = decode(h, l, r);
      if (m.mode == 0) begin
         n.mode = d; n.t = 0;
      end else if (m.mode != 3 && h) begin
         n.mode = 3; n.t = 0;
      end else if (m.t + 1 == period) begin
         n.mode = d; n.t = 0;
      end else begin
         n.t = m.t + 1;
      end
      return n;
   endfunction

   function automatic logic [7:0] mdl_side(mdl_t m, int lamps, int sd, int side);
      int step;
      logic [7:0] full;
      logic brk;
`ifdef TBIRD_BRAKE_EN
      brk = m.brk;
`else
      brk = 1'b0;
`endif
      step = m.t / sd;
      full = 8'((1 << lamps) - 1);
      if (m.mode == 3) return (step == 0) ? full : 8'd0;
      if (m.mode == side) return 8'((1 << ((step + 1) % (lamps + 1))) - 1);
      return brk ? full : 8'd0;
   endfunction

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, "_a_l"}, {5'b0, a_l}, mdl_side(ma, 3, 2, 1));
      chk({tag, "_a_r"}, {5'b0, a_r}, mdl_side(ma, 3, 2, 2));
      chk({tag, "_a_busy"}, {7'b0, a_busy}, (ma.mode != 0) ? 8'd1 : 8'd0);
      chk({tag, "_b_l"}, {6'b0, b_l}, mdl_side(mb, 2, 1, 1));
      chk({tag, "_b_r"}, {6'b0, b_r}, mdl_side(mb, 2, 1, 2));
      chk({tag, "_b_busy"}, {7'b0, b_busy}, (mb.mode != 0) ? 8'd1 : 8'd0);
   endtask

   task automatic mdl_reset();
      ma = '{0, 0, 1'b0};
      mb = '{0, 0, 1'b0};
   endtask

   task automatic cyc(string tag);
      @(posedge clk);
      if (reset) begin
         ma = mdl_next(ma, 3, 2, hazard, left, right, brake);
         mb = mdl_next(mb, 2, 1, hazard, left, right, brake);
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      seq = '{3'b001, 3'b001, 3'b011, 3'b011, 3'b111, 3'b111, 3'b000, 3'b000};
      reset = 1'b0; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
      mdl_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_a_l", {5'b0, a_l}, 8'd0);
      chk("rst_a_busy", {7'b0, a_busy}, 8'd0);
      check_all("rst");

      // Single-clock left pulse: full sweep, then idle.
      @(negedge clk);
      reset = 1'b1;
      left = 1'b1;
      cyc("pulse");
      left = 1'b0;
      chk("pulse_0", {5'b0, a_l}, {5'b0, seq[0]});
      for (int i = 1; i < 8; i++) begin
         cyc("pulse");
         chk("pulse_seq", {5'b0, a_l}, {5'b0, seq[i]});
      end
      cyc("pulse_end");
      chk("pulse_idle", {7'b0, a_busy}, 8'd0);

      // Right held: repeating sweep, left side dark.
      right = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cyc("rhold");
         chk("rhold_r", {5'b0, a_r}, {5'b0, seq[i % 8]});
         chk("rhold_l", {5'b0, a_l}, 8'd0);
      end
      right = 1'b0;
      repeat (10) cyc("rhold_rel");

      // Left and right together behave as hazard flashing.
      left = 1'b1; right = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc("both");
         chk("both_l", {5'b0, a_l}, ((i / 2) % 2 == 0) ? 8'd7 : 8'd0);
         chk("both_r", {5'b0, a_r}, ((i / 2) % 2 == 0) ? 8'd7 : 8'd0);
      end
      left = 1'b0; right = 1'b0;
      repeat (6) cyc("both_rel");

      // Hazard preempts a left sweep at 011.
      left = 1'b1;
      cyc("preempt");
      left = 1'b0;
      cyc("preempt");
      cyc("preempt");
      chk("preempt_mid", {5'b0, a_l}, 8'd3);
      hazard = 1'b1;
      cyc("preempt");
      hazard = 1'b0;
      chk("preempt_l", {5'b0, a_l}, 8'd7);
      chk("preempt_r", {5'b0, a_r}, 8'd7);
      repeat (8) cyc("preempt_rel");
      chk("preempt_idle", {7'b0, a_busy}, 8'd0);

      // Asynchronous reset mid-sweep, then restart on first edge.
      left = 1'b1;
      cyc("arst");
      left = 1'b0;
      cyc("arst");
      cyc("arst");
      #2 reset = 1'b0;
      mdl_reset();
      #1;
      chk("arst_l", {5'b0, a_l}, 8'd0);
      chk("arst_busy", {7'b0, a_busy}, 8'd0);
      check_all("arst");
      left = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      cyc("arst_rel");
      left = 1'b0;
      chk("arst_first", {5'b0, a_l}, 8'd1);
      repeat (10) cyc("arst_tail");

`ifdef TBIRD_BRAKE_EN
      brake = 1'b1;
      cyc("brake_idle");
      chk("brake_idle_l", {5'b0, a_l}, 8'd7);
      chk("brake_idle_r", {5'b0, a_r}, 8'd7);
      left = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc("brake_left");
         chk("brake_left_r", {5'b0, a_r}, 8'd7);
      end
      left = 1'b0; brake = 1'b0;
      repeat (10) cyc("brake_rel");
`endif

      // Random requests with occasional asynchronous reset.
      for (int i = 0; i < 800; i++) begin
         hazard = ($urandom_range(0, 11) == 0);
         left   = ($urandom_range(0, 3) == 0);
         right  = ($urandom_range(0, 3) == 0);
         brake  = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 149) == 0) begin
            #2 reset = 1'b0;
            mdl_reset();
            #1;
            check_all("rnd_rst");
            @(negedge clk);
            reset = 1'b1;
         end
         cyc("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
